// File: rtl/rf_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file,
// with bounded ownership locks and tagged 1-cycle read responses.
//
// state | meaning
// IDLE  | no owner, plain round-robin between requesters
// OWN0  | requester 0 holds a lock on the port
// OWN1  | requester 1 holds a lock on the port
module rf_access_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          r0_req_i,
  input  logic          r0_lock_i,
  input  logic          r0_we_i,
  input  logic [AW-1:0] r0_addr_i,
  input  logic [DW-1:0] r0_wdata_i,
  output logic          r0_gnt_o,
  output logic          r0_rvalid_o,
  output logic [DW-1:0] r0_rdata_o,
  input  logic          r1_req_i,
  input  logic          r1_lock_i,
  input  logic          r1_we_i,
  input  logic [AW-1:0] r1_addr_i,
  input  logic [DW-1:0] r1_wdata_i,
  output logic          r1_gnt_o,
  output logic          r1_rvalid_o,
  output logic [DW-1:0] r1_rdata_o,
  output logic [AW-1:0] rf_addr_o,
  output logic          rf_ce_o,
  output logic [DW-1:0] rf_data_in_o,
  input  logic [DW-1:0] rf_data_out_i,
  output logic          busy_o
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          pend_q, pend_d;
  logic          tag_q, tag_d;

  logic          owned, owner, owner_req, other_req, cap;
  logic          gnt_vld, gnt_id, gnt_lock, gnt_we;

  assign owned     = (state_q != ST_IDLE);
  assign owner     = (state_q == ST_OWN1);
  assign owner_req = owner ? r1_req_i : r0_req_i;
  assign other_req = owner ? r0_req_i : r1_req_i;
  assign cap       = (lock_cnt_q == CW'(MAX_LOCK));
  assign gnt_lock  = gnt_id ? r1_lock_i : r0_lock_i;
  assign gnt_we    = gnt_id ? r1_we_i : r0_we_i;

  // Grants are gated by reset so every output reads 0 while rst_ni is low.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!rst_ni) begin
      gnt_vld = 1'b0;
    end else if (owned && owner_req && !(other_req && cap)) begin
      gnt_vld = 1'b1;
      gnt_id  = owner;
    end else if (owned && owner_req) begin
      gnt_vld = 1'b1;
      gnt_id  = ~owner;
    end else if (r0_req_i && r1_req_i) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_q;
    end else if (r0_req_i || r1_req_i) begin
      gnt_vld = 1'b1;
      gnt_id  = r1_req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      pend_q     <= 1'b0;
      tag_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      pend_q     <= pend_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    pend_d     = 1'b0;
    tag_d      = tag_q;
    if (gnt_vld) begin
      last_d = gnt_id;
      pend_d = ~gnt_we;
      tag_d  = gnt_id;
      if (!gnt_lock) begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end else if (owned && (gnt_id == owner)) begin
        if (!cap) lock_cnt_d = lock_cnt_q + CW'(1);
      end else begin
        state_d    = gnt_id ? ST_OWN1 : ST_OWN0;
        lock_cnt_d = CW'(1);
      end
    end else begin
      state_d    = ST_IDLE;
      lock_cnt_d = '0;
    end
  end

  always_comb begin
    r0_gnt_o     = gnt_vld & ~gnt_id;
    r1_gnt_o     = gnt_vld & gnt_id;
    rf_ce_o      = gnt_vld & gnt_we;
    rf_addr_o    = '0;
    rf_data_in_o = '0;
    if (gnt_vld) begin
      rf_addr_o    = gnt_id ? r1_addr_i : r0_addr_i;
      rf_data_in_o = gnt_id ? r1_wdata_i : r0_wdata_i;
    end
    r0_rvalid_o = pend_q & ~tag_q;
    r1_rvalid_o = pend_q & tag_q;
    r0_rdata_o  = r0_rvalid_o ? rf_data_out_i : '0;
    r1_rdata_o  = r1_rvalid_o ? rf_data_out_i : '0;
    busy_o      = owned;
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural single-port
// register file (registered read, 1-cycle latency) attached.
module tb_rf_access_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MAX_LOCK = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_req = 0, r0_lock = 0, r0_we = 0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_req = 0, r1_lock = 0, r1_we = 0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rf_ce, busy;
  logic [DW-1:0] r0_rdata, r1_rdata, rf_din, rf_dout;
  logic [AW-1:0] rf_addr;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem [16];

  int tests = 0;
  int fails = 0;

  rf_access_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .r0_req_i(r0_req), .r0_lock_i(r0_lock), .r0_we_i(r0_we),
    .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
    .r0_gnt_o(r0_gnt), .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata),
    .r1_req_i(r1_req), .r1_lock_i(r1_lock), .r1_we_i(r1_we),
    .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
    .r1_gnt_o(r1_gnt), .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata),
    .rf_addr_o(rf_addr), .rf_ce_o(rf_ce), .rf_data_in_o(rf_din),
    .rf_data_out_i(rf_dout), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rf_ce) mem[rf_addr] <= rf_din;
    rf_dout <= mem[rf_addr];
  end

  task automatic idle_all();
    r0_req = 0; r0_lock = 0; r0_we = 0;
    r1_req = 0; r1_lock = 0; r1_we = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); idle_all(); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_all();
    @(negedge clk); pl_en = 1; pl_addr = 4'd2; pl_data = 8'h11;
    @(negedge clk); pl_addr = 4'd3; pl_data = 8'h22;
    @(negedge clk); pl_en = 0;
    #1;
    tests++; if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rf_ce, busy} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got %b exp 000000", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rf_ce, busy}); end
    tests++; if ({rf_addr, rf_din, r0_rdata, r1_rdata} !== 28'h0) begin
      fails++; $display("FAIL reset_buses got %h exp 0", {rf_addr, rf_din, r0_rdata, r1_rdata}); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_contention();
    @(negedge clk);
    r0_req = 1; r0_addr = 4'd2; r1_req = 1; r1_addr = 4'd3;
    #1;
    tests++; if ({r0_gnt, r1_gnt} !== 2'b10) begin
      fails++; $display("FAIL cont_c0_gnt got %b exp 10", {r0_gnt, r1_gnt}); end
    tests++; if (rf_addr !== 4'd2 || rf_ce !== 1'b0) begin
      fails++; $display("FAIL cont_c0_rf got addr %0d ce %b exp addr 2 ce 0", rf_addr, rf_ce); end
    @(negedge clk); r0_req = 0; #1;
    tests++; if ({r1_gnt, r0_gnt} !== 2'b10 || rf_addr !== 4'd3) begin
      fails++; $display("FAIL cont_c1_gnt got r1 %b r0 %b addr %0d exp 1 0 3", r1_gnt, r0_gnt, rf_addr); end
    tests++; if (r0_rvalid !== 1'b1 || r0_rdata !== 8'h11 || r1_rvalid !== 1'b0) begin
      fails++; $display("FAIL cont_c1_rsp got v %b d %h r1v %b exp 1 11 0", r0_rvalid, r0_rdata, r1_rvalid); end
    @(negedge clk); r1_req = 0; #1;
    tests++; if (r1_rvalid !== 1'b1 || r1_rdata !== 8'h22) begin
      fails++; $display("FAIL cont_c2_rsp got v %b d %h exp 1 22", r1_rvalid, r1_rdata); end
    tests++; if (r0_rvalid !== 1'b0 || r0_rdata !== 8'h00) begin
      fails++; $display("FAIL cont_c2_untagged got v %b d %h exp 0 00", r0_rvalid, r0_rdata); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    r0_req = 1; r0_we = 1; r0_addr = 4'd1; r0_wdata = 8'hA5;
    #1;
    tests++; if (r0_gnt !== 1'b1 || rf_ce !== 1'b1 || rf_addr !== 4'd1 || rf_din !== 8'hA5) begin
      fails++; $display("FAIL wr_cycle got gnt %b ce %b addr %0d din %h exp 1 1 1 a5", r0_gnt, rf_ce, rf_addr, rf_din); end
    @(negedge clk); r0_we = 0; r0_wdata = 8'h00; #1;
    tests++; if (r0_gnt !== 1'b1 || rf_ce !== 1'b0 || r0_rvalid !== 1'b0) begin
      fails++; $display("FAIL rd_cycle got gnt %b ce %b rvalid %b exp 1 0 0", r0_gnt, rf_ce, r0_rvalid); end
    @(negedge clk); r0_req = 0; #1;
    tests++; if (r0_rvalid !== 1'b1 || r0_rdata !== 8'hA5 || r1_rvalid !== 1'b0) begin
      fails++; $display("FAIL wr_rd_data got v %b d %h r1v %b exp 1 a5 0", r0_rvalid, r0_rdata, r1_rvalid); end
    @(negedge clk); #1;
    tests++; if (r0_rvalid !== 1'b0) begin
      fails++; $display("FAIL rvalid_pulse got %b exp 0", r0_rvalid); end
  endtask

  task automatic test_lock_limit();
    pulse_reset();
    r0_req = 1; r0_lock = 1; r0_addr = 4'd0;
    r1_req = 1; r1_addr = 4'd3;
    for (int i = 0; i < MAX_LOCK + 1; i++) begin
      logic exp0, exp_busy;
      exp0 = (i < MAX_LOCK);
      exp_busy = (i > 0);
      #1;
      tests++; if ({r0_gnt, r1_gnt} !== {exp0, ~exp0} || busy !== exp_busy) begin
        fails++; $display("FAIL lock_cyc%0d got gnt %b%b busy %b exp %b%b %b", i, r0_gnt, r1_gnt, busy, exp0, ~exp0, exp_busy); end
      @(negedge clk);
    end
    #1;
    tests++; if ({r0_gnt, r1_gnt} !== 2'b10 || busy !== 1'b0) begin
      fails++; $display("FAIL lock_after_switch got gnt %b%b busy %b exp 10 0", r0_gnt, r1_gnt, busy); end
    @(negedge clk); idle_all();
    @(negedge clk);
  endtask

  task automatic test_uncontended();
    @(negedge clk);
    r0_req = 1; r0_lock = 1; r0_addr = 4'd5;
    for (int i = 0; i < 10; i++) begin
      logic exp_busy;
      exp_busy = (i > 0);
      #1;
      tests++; if (r0_gnt !== 1'b1 || busy !== exp_busy) begin
        fails++; $display("FAIL hold_cyc%0d got gnt %b busy %b exp 1 %b", i, r0_gnt, busy, exp_busy); end
      @(negedge clk);
    end
    r0_lock = 0; #1;
    tests++; if (r0_gnt !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL unlock_cycle got gnt %b busy %b exp 1 1", r0_gnt, busy); end
    @(negedge clk); #1;
    tests++; if (busy !== 1'b0) begin
      fails++; $display("FAIL unlock_idle got busy %b exp 0", busy); end
    @(negedge clk); idle_all();
  endtask

  task automatic test_owner_drop();
    @(negedge clk);
    r0_req = 1; r0_lock = 1; r0_addr = 4'd6; #1;
    tests++; if (r0_gnt !== 1'b1) begin
      fails++; $display("FAIL drop_own got %b exp 1", r0_gnt); end
    @(negedge clk); r0_req = 0; r0_lock = 0; r1_req = 1; r1_addr = 4'd7; #1;
    tests++; if ({r0_gnt, r1_gnt} !== 2'b01 || busy !== 1'b1 || rf_addr !== 4'd7) begin
      fails++; $display("FAIL drop_handover got gnt %b%b busy %b addr %0d exp 01 1 7", r0_gnt, r1_gnt, busy, rf_addr); end
    @(negedge clk); idle_all();
  endtask

  task automatic test_reset_pending();
    @(negedge clk);
    r0_req = 1; r0_addr = 4'd2; #1;
    tests++; if (r0_gnt !== 1'b1) begin
      fails++; $display("FAIL rp_gnt got %b exp 1", r0_gnt); end
    @(posedge clk); #1;
    tests++; if (r0_rvalid !== 1'b1) begin
      fails++; $display("FAIL rp_pending got %b exp 1", r0_rvalid); end
    r0_req = 0; r1_req = 1; r1_addr = 4'd9;
    #1 rst_n = 0;
    #1;
    tests++; if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rf_ce, busy} !== 6'b0 || {rf_addr, r0_rdata} !== 12'h0) begin
      fails++; $display("FAIL rp_async got flags %b addr %0d d %h exp 0", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rf_ce, busy}, rf_addr, r0_rdata); end
    @(negedge clk); @(negedge clk);
    rst_n = 1; r1_req = 0; #1;
    tests++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
      fails++; $display("FAIL rp_discard got %b%b exp 00", r0_rvalid, r1_rvalid); end
    @(negedge clk);
    r0_req = 1; r0_addr = 4'd2; r1_req = 1; r1_addr = 4'd3; #1;
    tests++; if ({r0_gnt, r1_gnt} !== 2'b10) begin
      fails++; $display("FAIL rp_first_contention got %b exp 10", {r0_gnt, r1_gnt}); end
    @(negedge clk); idle_all();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write_read();
    test_lock_limit();
    test_uncontended();
    test_owner_drop();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
